// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges data-memory wait, multi-cycle
// multiply, taken branch and load-use hazards into one set of per-stage enables/flushes.
module pipe_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic             IDEX_MemRead_i,
    input  logic             branch_taken_i,
    input  logic             mul_start_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             stat_clr_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_flush_o,
    output logic             exmem_we_o,
    output logic             exmem_flush_o,
    output logic             memwb_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int MW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [MW-1:0] MUL_INIT = MW'(MUL_LAT - 2);

    state_e            state_q, state_d;
    logic [MW-1:0]     mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic freeze, load_use;
    logic pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, exmem_fl, memwb_fl;

    assign freeze   = dmem_req_i & ~dmem_ready_i;
    assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                      ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        ifid_fl   = 1'b0;
        idex_we   = 1'b1;
        idex_fl   = 1'b0;
        exmem_we  = 1'b1;
        exmem_fl  = 1'b0;
        memwb_fl  = 1'b0;

        if (freeze) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_fl = 1'b1;
            // A freeze inside MUL_WAIT parks the multiply without consuming a count.
            if (state_q != MUL_WAIT) state_d = MEM_WAIT;
        end else if (state_q == MUL_WAIT) begin
            if (mul_cnt_q != '0) begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                idex_we   = 1'b0;
                exmem_fl  = 1'b1;
                mul_cnt_d = mul_cnt_q - 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            // RUN, or MEM_WAIT releasing this cycle: decode as RUN
            state_d = RUN;
            if (mul_start_i) begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                idex_we   = 1'b0;
                exmem_fl  = 1'b1;
                mul_cnt_d = MUL_INIT;
                state_d   = MUL_WAIT;
            end else if (branch_taken_i) begin
                ifid_fl = 1'b1;
                idex_fl = 1'b1;
            end else if (load_use) begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                idex_fl = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr_i)
            stall_cnt_d = '0;
        else if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Everything is held inactive while reset is asserted.
    assign pc_we_o       = rst_n_i & pc_we;
    assign ifid_we_o     = rst_n_i & ifid_we;
    assign ifid_flush_o  = rst_n_i & ifid_fl;
    assign idex_we_o     = rst_n_i & idex_we;
    assign idex_flush_o  = rst_n_i & idex_fl;
    assign exmem_we_o    = rst_n_i & exmem_we;
    assign exmem_flush_o = rst_n_i & exmem_fl;
    assign memwb_flush_o = rst_n_i & memwb_fl;
    assign stall_cnt_o   = stall_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (MUL_LAT=4, CNT_W=4 so saturation is reachable).
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 4;

    // Output vector order: pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_flush
    localparam logic [7:0] O_DEF = 8'b1101_0100;
    localparam logic [7:0] O_FRZ = 8'b0000_0001;
    localparam logic [7:0] O_MUL = 8'b0000_0110;
    localparam logic [7:0] O_BR  = 8'b1111_1100;
    localparam logic [7:0] O_LU  = 8'b0001_1100;
    localparam logic [7:0] O_RST = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic idex_memread, branch_taken, mul_start, dmem_req, dmem_ready, stat_clr;
    logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt), .IDEX_Rt_i(idex_rt),
        .IDEX_MemRead_i(idex_memread), .branch_taken_i(branch_taken),
        .mul_start_i(mul_start), .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
        .stat_clr_i(stat_clr),
        .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
        .idex_we_o(idex_we), .idex_flush_o(idex_flush),
        .exmem_we_o(exmem_we), .exmem_flush_o(exmem_flush), .memwb_flush_o(memwb_flush),
        .stall_cnt_o(stall_cnt), .state_o(state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [7:0] exp_o, input logic [1:0] exp_st);
        #1;
        chk({tag, " outs"}, {24'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                             exmem_we, exmem_flush, memwb_flush}, {24'd0, exp_o});
        chk({tag, " state"}, {30'd0, state}, {30'd0, exp_st});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {ifid_rs, ifid_rt, idex_rt} = '0;
        {idex_memread, branch_taken, mul_start, dmem_req, dmem_ready, stat_clr} = '0;

        // reset state
        #12;
        chk_cyc("reset", O_RST, 2'd0);
        chk("reset cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        chk_cyc("idle", O_DEF, 2'd0);
        tick();
        chk_cyc("idle2", O_DEF, 2'd0);

        // load-use: one cycle stall
        idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        chk_cyc("lu", O_LU, 2'd0);
        tick();
        idex_memread = 1'b0;
        chk_cyc("lu clear", O_DEF, 2'd0);
        chk("lu cnt", 32'(stall_cnt), 32'd1);
        idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        chk_cyc("lu r0", O_DEF, 2'd0);
        tick();
        idex_memread = 1'b0;
        chk("lu r0 cnt", 32'(stall_cnt), 32'd1);

        // multiply: state 0,1,1,1,0; three stall cycles
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr cnt", 32'(stall_cnt), 32'd0);
        mul_start = 1'b1;
        chk_cyc("mul0", O_MUL, 2'd0);
        tick();
        chk_cyc("mul1", O_MUL, 2'd1);
        tick();
        chk_cyc("mul2", O_MUL, 2'd1);
        tick();
        chk_cyc("mul3", O_DEF, 2'd1);
        tick();
        mul_start = 1'b0;
        chk_cyc("mul4", O_DEF, 2'd0);
        chk("mul cnt", 32'(stall_cnt), 32'd3);

        // memory wait: 5 freeze cycles then same-cycle release
        dmem_req = 1'b1; dmem_ready = 1'b0;
        chk_cyc("mem0", O_FRZ, 2'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk_cyc("memN", O_FRZ, 2'd2);
        end
        tick();
        dmem_ready = 1'b1;
        chk_cyc("mem rel", O_DEF, 2'd2);
        tick();
        dmem_req = 1'b0; dmem_ready = 1'b0;
        chk_cyc("mem after", O_DEF, 2'd0);
        chk("mem cnt", 32'(stall_cnt), 32'd8);

        // branch beats load-use
        branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd8; ifid_rt = 5'd8;
        chk_cyc("br+lu", O_BR, 2'd0);
        tick();
        branch_taken = 1'b0; idex_memread = 1'b0;
        chk("br cnt", 32'(stall_cnt), 32'd8);

        // branch held through a memory wait, applied on release
        branch_taken = 1'b1; dmem_req = 1'b1;
        chk_cyc("brmem0", O_FRZ, 2'd0);
        tick();
        chk_cyc("brmem1", O_FRZ, 2'd2);
        tick();
        dmem_ready = 1'b1;
        chk_cyc("brmem rel", O_BR, 2'd2);
        tick();
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        chk_cyc("brmem after", O_DEF, 2'd0);
        chk("brmem cnt", 32'(stall_cnt), 32'd10);

        // saturation at 15, then clear during a stall
        dmem_req = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("sat cnt", 32'(stall_cnt), 32'd15);
        stat_clr = 1'b1;
        chk_cyc("clr frz", O_FRZ, 2'd2);
        tick();
        stat_clr = 1'b0;
        chk("clr stall cnt", 32'(stall_cnt), 32'd0);
        dmem_ready = 1'b1;
        tick();
        dmem_req = 1'b0; dmem_ready = 1'b0;
        chk_cyc("sat exit", O_DEF, 2'd0);

        // reset in MUL_WAIT with mul_cnt=1
        mul_start = 1'b1;
        tick();
        tick();
        chk_cyc("pre rst", O_MUL, 2'd1);
        rst_n = 1'b0;
        chk_cyc("mid rst", O_RST, 2'd0);
        chk("mid rst cnt", 32'(stall_cnt), 32'd0);
        mul_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_cyc("post rst", O_DEF, 2'd0);
        mul_start = 1'b1;
        chk_cyc("remul0", O_MUL, 2'd0);
        tick();
        chk_cyc("remul1", O_MUL, 2'd1);
        tick();
        chk_cyc("remul2", O_MUL, 2'd1);
        tick();
        chk_cyc("remul3", O_DEF, 2'd1);
        tick();
        mul_start = 1'b0;
        chk_cyc("remul4", O_DEF, 2'd0);
        chk("remul cnt", 32'(stall_cnt), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges four hazard sources into one consistent set of per-stage write-enable and flush controls:
- load-use (detected internally),
- EX-resolved taken branch,
- multi-cycle multiply occupying EX,
- data-memory wait handshake.

It replaces per-hazard stall wiring with one registered FSM and has no simulation delays, so it is fully synthesizable.

## Interface
- MUL_LAT, 4: total EX cycles a multiply occupies; legal range ≥2.
- CNT_W, 16: width of the stall-cycle performance counter.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- IFID_Rs_i  in  5  Rs of the instruction in ID.
- IFID_Rt_i  in  5  Rt of the instruction in ID.
- IDEX_Rt_i  in  5  destination Rt of the instruction in EX.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- branch_taken_i  in  1  branch in EX resolved taken; PC input mux already selects the target.
- mul_start_i  in  1  multiply present in EX; held high while it remains there.
- dmem_req_i  in  1  MEM stage issues a data-memory access.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- stat_clr_i  in  1  synchronous clear of stall_cnt_o.
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  load NOP into IF/ID.
- idex_we_o  out  1  ID/EX write enable.
- idex_flush_o  out  1  load bubble into ID/EX.
- exmem_we_o  out  1  EX/MEM write enable.
- exmem_flush_o  out  1  load bubble into EX/MEM.
- memwb_flush_o  out  1  load bubble into MEM/WB.
- stall_cnt_o  out  CNT_W  count of cycles with pc_we_o=0.
- state_o  out  2  FSM state: RUN=0, MUL_WAIT=1, MEM_WAIT=2.

## Operation
- Registered state: state, mul_cnt (width clog2(MUL_LAT)), stall_cnt. Control outputs are a Mealy decode of state and current inputs.
- Default (no hazard): all *_we_o=1, all *_flush_o=0.
- Priority, highest first: MEM freeze > multiply > branch > load-use.
- MEM freeze:
  - Condition: dmem_req_i=1 and dmem_ready_i=0 in RUN or MEM_WAIT.
  - Outputs: all *_we_o=0, memwb_flush_o=1, other flushes 0.
  - RUN→MEM_WAIT.
- MEM_WAIT:
  - dmem_ready_i=1 or dmem_req_i=0: outputs decode per RUN rules the same cycle; next state is RUN.
  - Otherwise: stay in MEM_WAIT and hold the freeze.
- Multiply start (RUN, mul_start_i=1, no freeze):
  - Outputs: pc_we_o=ifid_we_o=idex_we_o=0, exmem_flush_o=1, exmem_we_o=1.
  - mul_cnt←MUL_LAT-2; state→MUL_WAIT.
- MUL_WAIT:
  - mul_cnt≠0: same stall outputs as multiply start; mul_cnt decrements.
  - mul_cnt=0: default outputs (multiply advances); state→RUN.
  - mul_start_i is ignored in this state.
  - If dmem_req_i=1 and dmem_ready_i=0 (unreachable in legal flow): freeze outputs, mul_cnt does not decrement, state unchanged.
- Branch (branch_taken_i=1, no higher event): pc_we_o=1, ifid_flush_o=1, idex_flush_o=1, all other enables 1.
- Load-use:
  - Condition: IDEX_MemRead_i=1 and IDEX_Rt_i≠0 and (IDEX_Rt_i==IFID_Rs_i or IDEX_Rt_i==IFID_Rt_i), no higher event.
  - Outputs: pc_we_o=0, ifid_we_o=0, idex_flush_o=1, others default.
  - Self-clears the next cycle because the bubble now occupies EX.
- A branch during a freeze is not latched. branch_taken_i stays asserted because EX is held, and the branch is applied on release.
- stall_cnt:
  - Increments when pc_we_o=0.
  - Saturates at all-ones.
  - stat_clr_i=1 forces 0 and takes priority over increment.

## Timing
- Reset (rst_n_i=0, asynchronous):
  - state=RUN, mul_cnt=0, stall_cnt_o=0, state_o=0.
  - All *_we_o=0 and all *_flush_o=0 while reset is asserted.
  - Default outputs resume in the first cycle after release.
  - Reset mid-multiply or mid-wait discards all pending sequencing.
- Load-use stall: exactly 1 cycle.
- Multiply: EX occupancy MUL_LAT cycles; stall outputs asserted MUL_LAT-1 cycles, counted from the cycle mul_start_i is first seen.
- Memory freeze: zero-cycle release; enables return high in the same cycle dmem_ready_i=1.
- Branch: flush is a single cycle, in the cycle branch_taken_i is sampled high.
- Counter: stall_cnt_o updates one edge after the stalled cycle.

## Test plan
- Load-use: IDEX_MemRead_i=1, IDEX_Rt_i=8, IFID_Rs_i=8 → one cycle of pc_we_o=0, ifid_we_o=0, idex_flush_o=1. Repeat with IDEX_Rt_i=0 → no stall.
- Multiply: MUL_LAT=4, mul_start_i held 4 cycles → state_o 0,1,1,1,0; stall outputs high 3 cycles; stall_cnt_o=3.
- Memory wait: dmem_req_i=1, dmem_ready_i=0 for 5 cycles, then 1 → freeze 5 cycles with memwb_flush_o=1; release in the ready cycle; state_o returns to 0 next edge.
- Simultaneous events: branch_taken_i=1 with load-use → branch flush only, pc_we_o=1. Branch during memory wait → no flush until release, then ifid_flush_o=idex_flush_o=1 for one cycle.
- Counter: force saturation with CNT_W=4 (15 stays 15). stat_clr_i with a concurrent stall → 0.
- Reset mid-MUL_WAIT (mul_cnt=1) → immediate state_o=0, all outputs 0, stall_cnt_o=0. After release, a fresh mul_start_i yields the full MUL_LAT-1 stall.
